// File: rtl/edge_step_counter.sv
// Modulo-CNT_MAX up/down counter stepped by synchronised edges of an async input.
// Load beats step beats hold; ovf/unf are registered one-cycle wrap pulses for cascading.
module edge_step_counter #(
    parameter int WIDTH       = 4,
    parameter int CNT_MAX     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             in_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             ovf_o,
    output logic             unf_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(CNT_MAX - 1);

    generate
        if (CNT_MAX < 2 || CNT_MAX > (1 << WIDTH)) begin : g_bad_cnt_max
            $error("edge_step_counter: CNT_MAX out of range 2..2**WIDTH");
        end
        if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
            $error("edge_step_counter: SYNC_STAGES out of range 0..3");
        end
        if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge
            $error("edge_step_counter: EDGE_MODE out of range 0..2");
        end
    endgenerate

    logic in_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign in_s = in_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) sync_q <= '0;
                else       sync_q <= SYNC_STAGES'({sync_q, in_i});
            end
            assign in_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // in_prev tracks in_s even while disabled so enabling never sees a stale edge.
    logic in_prev_q;
    logic rise, fall, edge_det, step;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) in_prev_q <= 1'b0;
        else       in_prev_q <= in_s;
    end

    assign rise = in_s & ~in_prev_q;
    assign fall = ~in_s & in_prev_q;

    always_comb begin
        edge_det = rise | fall;
        case (EDGE_MODE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
        endcase
    end

    assign step = en_i & edge_det;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (load_i) begin
            // Out-of-range loads clamp to the top value instead of wrapping.
            cnt_d = (load_val_i > MAX_V) ? MAX_V : load_val_i;
        end else if (step) begin
            if (!dir_i) begin
                if (cnt_q == MAX_V) begin
                    cnt_d = '0;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = MAX_V;
                    unf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
    assign unf_o = unf_q;
    assign tc_o  = dir_i ? (cnt_q == '0) : (cnt_q == MAX_V);

endmodule

// File: tb/tb_edge_step_counter.sv
// Bench for edge_step_counter: three parameter sets driven from shared inputs,
// directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_edge_step_counter;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       en_i = 1'b0, in_i = 1'b0, dir_i = 1'b0, load_i = 1'b0;
    logic [3:0] load_val_i = 4'd0;

    logic [3:0] cnt_w [3];
    logic       ovf_w [3];
    logic       unf_w [3];
    logic       tc_w  [3];

    always #5 clk_i = ~clk_i;

    // 0: defaults (rising, 2 sync, mod 8); 1: both edges; 2: falling, no sync, mod 16
    edge_step_counter #(.WIDTH(4), .CNT_MAX(8), .SYNC_STAGES(2), .EDGE_MODE(0)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .in_i(in_i), .dir_i(dir_i),
        .load_i(load_i), .load_val_i(load_val_i),
        .cnt_o(cnt_w[0]), .ovf_o(ovf_w[0]), .unf_o(unf_w[0]), .tc_o(tc_w[0]));
    edge_step_counter #(.WIDTH(4), .CNT_MAX(8), .SYNC_STAGES(2), .EDGE_MODE(2)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .in_i(in_i), .dir_i(dir_i),
        .load_i(load_i), .load_val_i(load_val_i),
        .cnt_o(cnt_w[1]), .ovf_o(ovf_w[1]), .unf_o(unf_w[1]), .tc_o(tc_w[1]));
    edge_step_counter #(.WIDTH(4), .CNT_MAX(16), .SYNC_STAGES(0), .EDGE_MODE(1)) dut_c (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .in_i(in_i), .dir_i(dir_i),
        .load_i(load_i), .load_val_i(load_val_i),
        .cnt_o(cnt_w[2]), .ovf_o(ovf_w[2]), .unf_o(unf_w[2]), .tc_o(tc_w[2]));

    int n_vec = 0;
    int n_err = 0;

    int M [3] = '{8, 8, 16};
    int S [3] = '{2, 2, 0};
    int E [3] = '{0, 2, 1};

    int m_cnt [3];
    bit m_ovf [3];
    bit m_unf [3];
    bit past  [3][5];   // past[d][j] = value of in at the clock edge j cycles back

    function automatic bit m_tc(int d);
        return dir_i ? (m_cnt[d] == 0) : (m_cnt[d] == M[d] - 1);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_cnt[d] = 0;
            m_ovf[d] = 1'b0;
            m_unf[d] = 1'b0;
            for (int j = 0; j < 5; j++) past[d][j] = 1'b0;
        end
    endtask

    // One clock: evaluate the model on the inputs present at the edge, then settle.
    task automatic tick();
        int nc [3];
        bit no [3];
        bit nu [3];
        bit ins, prv, ed;
        for (int d = 0; d < 3; d++) begin
            ins = (S[d] == 0) ? in_i : past[d][S[d]];
            prv = past[d][S[d] + 1];
            case (E[d])
                0:       ed = ins & ~prv;
                1:       ed = ~ins & prv;
                default: ed = ins ^ prv;
            endcase
            nc[d] = m_cnt[d];
            no[d] = 1'b0;
            nu[d] = 1'b0;
            if (load_i) begin
                nc[d] = (int'(load_val_i) > M[d] - 1) ? M[d] - 1 : int'(load_val_i);
            end else if (en_i && ed) begin
                if (!dir_i) begin
                    nc[d] = (m_cnt[d] + 1) % M[d];
                    no[d] = (m_cnt[d] + 1 == M[d]);
                end else begin
                    nc[d] = (m_cnt[d] + M[d] - 1) % M[d];
                    nu[d] = (m_cnt[d] == 0);
                end
            end
            for (int j = 4; j > 1; j--) past[d][j] = past[d][j-1];
            past[d][1] = in_i;
        end
        @(posedge clk_i);
        #1;
        for (int d = 0; d < 3; d++) begin
            m_cnt[d] = nc[d];
            m_ovf[d] = no[d];
            m_unf[d] = nu[d];
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #2;
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        model_reset();
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if ({cnt_w[d], ovf_w[d], unf_w[d], tc_w[d]} !== 7'b0) begin
                n_err++;
                $display("FAIL reset dut%0d: got cnt=%0d ovf=%b unf=%b tc=%b want all 0",
                         d, cnt_w[d], ovf_w[d], unf_w[d], tc_w[d]);
            end
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_count_up();
        int ovf_seen = 0;
        en_i = 1'b1; dir_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            for (int t = 0; t < 6; t++) begin
                in_i = (t < 3);
                tick();
                if (ovf_w[0]) begin
                    ovf_seen++;
                    n_vec++;
                    if (cnt_w[0] !== 4'd0) begin
                        n_err++;
                        $display("FAIL count_up ovf_cnt: got cnt=%0d with ovf, want 0", cnt_w[0]);
                    end
                end
            end
            n_vec++;
            if (cnt_w[0] !== 4'(i % 8)) begin
                n_err++;
                $display("FAIL count_up edge%0d: got %0d want %0d", i, cnt_w[0], i % 8);
            end
            if (i == 7) begin
                n_vec++;
                if (tc_w[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL count_up tc: got %b want 1", tc_w[0]);
                end
            end
        end
        n_vec++;
        if (ovf_seen != 1) begin
            n_err++;
            $display("FAIL count_up ovf_width: got %0d cycles want 1", ovf_seen);
        end
    endtask

    task automatic test_count_down();
        int unf_seen = 0;
        dir_i = 1'b1;
        load_i = 1'b1; load_val_i = 4'd0;
        tick();
        load_i = 1'b0;
        n_vec++;
        if (cnt_w[0] !== 4'd0 || tc_w[0] !== 1'b1) begin
            n_err++;
            $display("FAIL count_down start: got cnt=%0d tc=%b want cnt=0 tc=1", cnt_w[0], tc_w[0]);
        end
        for (int i = 1; i <= 4; i++) begin
            for (int t = 0; t < 6; t++) begin
                in_i = (t < 3);
                tick();
                if (unf_w[0]) unf_seen++;
            end
            if (i == 1) begin
                n_vec++;
                if (cnt_w[0] !== 4'd7) begin
                    n_err++;
                    $display("FAIL count_down wrap: got %0d want 7", cnt_w[0]);
                end
            end
        end
        n_vec++;
        if (cnt_w[0] !== 4'd4) begin
            n_err++;
            $display("FAIL count_down final: got %0d want 4", cnt_w[0]);
        end
        n_vec++;
        if (unf_seen != 1) begin
            n_err++;
            $display("FAIL count_down unf_width: got %0d cycles want 1", unf_seen);
        end
    endtask

    task automatic test_load();
        dir_i = 1'b0;
        load_i = 1'b1; load_val_i = 4'd12;
        tick();
        load_i = 1'b0;
        n_vec++;
        if (cnt_w[0] !== 4'd7 || ovf_w[0] !== 1'b0 || unf_w[0] !== 1'b0 || tc_w[0] !== 1'b1) begin
            n_err++;
            $display("FAIL load_clamp: got cnt=%0d ovf=%b unf=%b tc=%b want cnt=7 ovf=0 unf=0 tc=1",
                     cnt_w[0], ovf_w[0], unf_w[0], tc_w[0]);
        end
        n_vec++;
        if (cnt_w[2] !== 4'd12) begin
            n_err++;
            $display("FAIL load_mod16: got %0d want 12", cnt_w[2]);
        end
        load_val_i = 4'd3;
        in_i = 1'b1;
        tick();
        tick();
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        n_vec++;
        if (cnt_w[0] !== 4'd3 || ovf_w[0] !== 1'b0) begin
            n_err++;
            $display("FAIL load_vs_step: got cnt=%0d ovf=%b want cnt=3 ovf=0", cnt_w[0], ovf_w[0]);
        end
        repeat (3) tick();
        in_i = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (cnt_w[0] !== 4'd3) begin
            n_err++;
            $display("FAIL load_step_dropped: got %0d want 3", cnt_w[0]);
        end
    endtask

    task automatic test_enable();
        en_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_i = 1'b1; repeat (3) tick();
            in_i = 1'b0; repeat (3) tick();
        end
        in_i = 1'b1; repeat (3) tick();
        en_i = 1'b1;
        repeat (4) tick();
        n_vec++;
        if (cnt_w[0] !== 4'd3) begin
            n_err++;
            $display("FAIL enable_stale: got %0d want 3", cnt_w[0]);
        end
        in_i = 1'b0; repeat (3) tick();
        in_i = 1'b1; repeat (3) tick();
        in_i = 1'b0; repeat (3) tick();
        n_vec++;
        if (cnt_w[0] !== 4'd4) begin
            n_err++;
            $display("FAIL enable_resume: got %0d want 4", cnt_w[0]);
        end
    endtask

    task automatic test_both_edges();
        do_reset();
        en_i = 1'b1; dir_i = 1'b0; load_i = 1'b0; in_i = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            in_i = ~in_i;
            tick();
            tick();
            n_vec++;
            if (cnt_w[1] !== 4'(t - 1)) begin
                n_err++;
                $display("FAIL both_edges early%0d: got %0d want %0d", t, cnt_w[1], t - 1);
            end
            tick();
            n_vec++;
            if (cnt_w[1] !== 4'(t)) begin
                n_err++;
                $display("FAIL both_edges lat%0d: got %0d want %0d", t, cnt_w[1], t);
            end
        end
        n_vec++;
        if (cnt_w[0] !== 4'd2) begin
            n_err++;
            $display("FAIL both_edges rising_only: got %0d want 2", cnt_w[0]);
        end
    endtask

    task automatic test_async_reset();
        load_i = 1'b1; load_val_i = 4'd7;
        tick();
        load_i = 1'b0;
        in_i = 1'b1;
        repeat (3) tick();
        n_vec++;
        if (ovf_w[0] !== 1'b1 || cnt_w[0] !== 4'd0) begin
            n_err++;
            $display("FAIL async_reset setup: got cnt=%0d ovf=%b want cnt=0 ovf=1", cnt_w[0], ovf_w[0]);
        end
        #2;
        rst_i = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (cnt_w[d] !== 4'd0 || ovf_w[d] !== 1'b0 || unf_w[d] !== 1'b0) begin
                n_err++;
                $display("FAIL async_reset dut%0d: got cnt=%0d ovf=%b unf=%b want 0",
                         d, cnt_w[d], ovf_w[d], unf_w[d]);
            end
        end
        model_reset();
        in_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (3) tick();
        in_i = 1'b1; repeat (3) tick();
        in_i = 1'b0; repeat (3) tick();
        n_vec++;
        if (cnt_w[0] !== 4'd1) begin
            n_err++;
            $display("FAIL async_reset resume: got %0d want 1", cnt_w[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        en_i = 1'b1; dir_i = 1'b0; load_i = 1'b0; in_i = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) in_i = ~in_i;
            en_i = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 31) == 0) dir_i = ~dir_i;
            load_i = ($urandom_range(0, 15) == 0);
            load_val_i = 4'($urandom);
            tick();
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if ({cnt_w[d], ovf_w[d], unf_w[d], tc_w[d]} !==
                    {4'(m_cnt[d]), m_ovf[d], m_unf[d], m_tc(d)}) begin
                    n_err++;
                    $display("FAIL random dut%0d cyc%0d: got cnt=%0d ovf=%b unf=%b tc=%b want cnt=%0d ovf=%b unf=%b tc=%b",
                             d, n, cnt_w[d], ovf_w[d], unf_w[d], tc_w[d],
                             m_cnt[d], m_ovf[d], m_unf[d], m_tc(d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_enable();
        test_both_edges();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
